mac_pe_feeder: RTL
==================

# mac_pe_feeder

Operand sequencer and result collector for the 16x16->32 MAC processing element. It holds a pair of operand vectors loaded over a simple write port. On `start` it streams the vectors into the PE's `a`/`b` inputs one pair per cycle, waits out the PE pipeline, and returns the dot product on a valid/ready result port. The PE never clears its accumulator, so the feeder derives each result as the difference between `pe_c` after the run and `pe_c` before it.

## Interface
- `DEPTH`, default 8: operand buffer entries, i.e. the maximum vector length.
- `DW`, default 16: operand width; matches PE `a`/`b`.
- `CW`, default 32: accumulator width; matches PE `c`.
- `PE_LAT`, default 1: cycles from an operand pair at the PE inputs to its effect on `pe_c`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: operand buffer write strobe.
- `wr_addr` in $clog2(DEPTH): buffer index to write.
- `wr_a` in DW: a-operand write data.
- `wr_b` in DW: b-operand write data.
- `start` in 1: begin a run; sampled only while `busy`=0.
- `len` in $clog2(DEPTH)+1: vector length, sampled with `start`.
- `busy` out 1: run in progress or result not yet taken.
- `pe_a` out DW: drives PE `a`; registered.
- `pe_b` out DW: drives PE `b`; registered.
- `pe_c` in CW: PE accumulator output.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out CW: dot product, modulo 2^CW.

## Operation
- Reset (`rst`=0, asynchronous):
  - `pe_a`, `pe_b`, `res_data`, `res_valid`, `busy` = 0.
  - Both buffers cleared to 0; state forced to IDLE.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - `pe_a`/`pe_b` held at 0, so the PE accumulates nothing.
  - `start`=1 with `len`≥1 at an edge:
    - `base` <= `pe_c`, `busy` <= 1, `pe_a`/`pe_b` <= buffer[0], index <= 1.
    - Goes to STREAM if `len`>1, otherwise DRAIN.
  - `len`>DEPTH is clamped to DEPTH.
  - `start` with `len`=0: `res_data` <= 0, `res_valid` <= 1, `busy` <= 1, go to DONE.
- STREAM:
  - Each edge drives buffer[index] and increments index.
  - After the edge that drives entry `len`-1, go to DRAIN.
- DRAIN:
  - `pe_a`/`pe_b` <= 0 on entry.
  - Wait PE_LAT edges, then `res_data` <= `pe_c` - `base` (CW-bit wrap), `res_valid` <= 1, go to DONE.
- DONE:
  - `res_data` is held stable while `res_valid`=1 and `res_ready`=0.
  - At an edge with `res_ready`=1: `res_valid` <= 0, `busy` <= 0, go to IDLE.
  - A new `start` is accepted no earlier than the following edge.
- `start` while `busy`=1 is ignored; it is not queued.
- Arithmetic: subtraction is unsigned mod 2^CW. The result is correct whenever the true sum fits in CW bits, regardless of PE accumulator wrap-around.

## Timing
- Start edge E0 drives pair 0. Pair i is driven at edge Ei; the PE adds it at E(i+PE_LAT).
- `res_valid` rises at edge E(len+PE_LAT), i.e. `len`+PE_LAT cycles after the start edge.
  - Example: `len`=2, PE_LAT=1 gives `res_valid` after E3.
- `pe_a`/`pe_b` return to 0 at edge E`len`.
- Minimum start-to-start spacing: `len`+PE_LAT+2 cycles with `res_ready` held at 1.
- Writes when `busy`=0 take effect at the edge; a read of the same index on that edge sees the old data.

## Configuration
- `MAC_FEEDER_WRBUSY_EN`:
  - Defined: `wr_en` is honoured while `busy`=1, so the next vector can be loaded during a run. A write to the entry being driven on the same edge takes effect after the read.
  - Undefined: `wr_en` is ignored while `busy`=1, and the buffers are frozen for the whole run.

## Test plan
- Basic run, from `pe_c`=0:
  - Stimulus: write a=[10,30], b=[20,40]; `start`, `len`=2, `res_ready`=1.
  - Required: `pe_a`,`pe_b` = (10,20) then (30,40) then (0,0); `res_valid` after 3 edges with `res_data`=1400; `busy` low one edge later.
- Non-zero base:
  - Stimulus: directly after the basic run, write a=[1,2], b=[3,4]; `start`, `len`=2.
  - Required: `res_data`=11 while PE `c`=1411.
- Wrap-around:
  - Stimulus: preload PE so `pe_c`=0xFFFFFFF0; run a=[4], b=[8].
  - Required: `res_data`=0x20 while `pe_c`=0x00000010.
- Degenerate length and backpressure:
  - Stimulus: `start` with `len`=0, then hold `res_ready`=0 for 5 cycles while toggling `start`.
  - Required: `res_valid`=1 after 1 edge with `res_data`=0, stable for all 5 cycles; no second run starts; `pe_a`/`pe_b` stay 0.
- Length clamp:
  - Stimulus: `len`=DEPTH+1 with all entries a=1, b=1.
  - Required: `res_data`=DEPTH=8.
- Reset mid-operation:
  - Stimulus: drive `rst`=0 during STREAM at pair 1.
  - Required: `pe_a`/`pe_b`/`busy`/`res_valid` go to 0 immediately without waiting for a clock edge; after release, a fresh run with a=[10,30], b=[20,40] returns 1400 relative to the new base.

Source files
------------

// File: rtl/mac_pe_feeder.sv
// Operand sequencer and result collector for a 16x16->32 accumulating MAC PE.
// Optional feature macro: MAC_FEEDER_WRBUSY_EN (allow buffer writes during a run).
module mac_pe_feeder #(
    parameter int DEPTH  = 8,
    parameter int DW     = 16,
    parameter int CW     = 32,
    parameter int PE_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DW-1:0]              wr_a,
    input  logic [DW-1:0]              wr_b,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    output logic                       busy,
    output logic [DW-1:0]              pe_a,
    output logic [DW-1:0]              pe_b,
    input  logic [CW-1:0]              pe_c,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [CW-1:0]              res_data,
    output logic [1:0]                 state_dbg
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LENW = AW + 1;
    localparam int LW   = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    // Result handshake: res_data is offered while res_valid=1 and is consumed
    // on the first rising edge where res_valid and res_ready are both high.

    state_t              state, state_next;
    logic [DW-1:0]       buf_a [DEPTH];
    logic [DW-1:0]       buf_b [DEPTH];
    logic [CW-1:0]       base;
    logic [AW-1:0]       idx;
    logic [LENW-1:0]     run_len;
    logic [LENW-1:0]     len_eff;
    logic [LW-1:0]       lat_cnt;
    logic                wr_ok;

    assign state_dbg = state;

`ifdef MAC_FEEDER_WRBUSY_EN
    assign wr_ok = wr_en;
`else
    assign wr_ok = wr_en && !busy;
`endif

    always_comb begin
        state_next = state;
        len_eff    = (len > LENW'(DEPTH)) ? LENW'(DEPTH) : len;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_eff == '0)
                        state_next = DONE;
                    else if (len_eff > LENW'(1))
                        state_next = STREAM;
                    else
                        state_next = DRAIN;
                end
            end
            STREAM: begin
                if ({1'b0, idx} == run_len - LENW'(1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (lat_cnt == LW'(PE_LAT))
                    state_next = DONE;
            end
            DONE: begin
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
            pe_a      <= '0;
            pe_b      <= '0;
            base      <= '0;
            idx       <= '0;
            run_len   <= '0;
            lat_cnt   <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Non-blocking write: a same-edge read of this index sees old data.
            if (wr_ok) begin
                buf_a[wr_addr] <= wr_a;
                buf_b[wr_addr] <= wr_b;
            end
            case (state)
                IDLE: begin
                    pe_a <= '0;
                    pe_b <= '0;
                    if (start) begin
                        busy    <= 1'b1;
                        idx     <= AW'(1);
                        run_len <= len_eff;
                        lat_cnt <= '0;
                        if (len_eff == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                        end else begin
                            base <= pe_c;
                            pe_a <= buf_a[0];
                            pe_b <= buf_b[0];
                        end
                    end
                end
                STREAM: begin
                    pe_a <= buf_a[idx];
                    pe_b <= buf_b[idx];
                    idx  <= idx + AW'(1);
                end
                DRAIN: begin
                    pe_a <= '0;
                    pe_b <= '0;
                    // The PE never clears, so the run's sum is the accumulator delta.
                    if (lat_cnt == LW'(PE_LAT)) begin
                        res_data  <= pe_c - base;
                        res_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
